// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a prefetch queue.
// Issues in-order fetch requests while queue plus in-flight requests leave room,
// buffers responses with their PCs, and hands them to ID under valid/ready.
// A redirect flushes the queue and drops responses still owed to the old stream.
module if_prefetch_unit #(
    parameter int unsigned      NBITS    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [NBITS-1:0] RESET_PC = '0,
    parameter logic [NBITS-1:0] PCINC    = NBITS'(4)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       o_imem_req,
    output logic [NBITS-1:0]           o_imem_addr,
    input  logic                       i_imem_gnt,
    input  logic                       i_imem_rvalid,
    input  logic [NBITS-1:0]           i_imem_rdata,
    output logic                       o_inst_valid,
    output logic [NBITS-1:0]           o_inst,
    output logic [NBITS-1:0]           o_inst_pc,
    output logic [NBITS-1:0]           o_next_pc,
    input  logic                       i_id_ready,
    input  logic                       i_redirect,
    input  logic [NBITS-1:0]           i_redirect_addr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [NBITS-1:0] ALIGN_MASK = {{(NBITS-2){1'b1}}, 2'b00};

    // Control state
    logic [NBITS-1:0] fpc_q, fpc_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]    ifr_q, ifr_d, ifw_q, ifw_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    outst_q, outst_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic             err_q, err_d;

    // Storage (not reset)
    logic [NBITS-1:0] inst_mem [DEPTH];
    logic [NBITS-1:0] pc_mem   [DEPTH];
    logic [NBITS-1:0] infl_pc  [DEPTH];

    logic [CW:0]      used;
    logic             has_credit;
    logic             grant;
    logic             rsp_ok;
    logic             push;
    logic             pop;
    logic             inst_valid;
    logic [NBITS-1:0] head_pc;

    // Handshake decode; credit uses registered occupancy only
    always_comb begin
        used       = {1'b0, count_q} + {1'b0, outst_q};
        has_credit = used < DEPTH_W;
        o_imem_req = rst & ~i_redirect & has_credit;
        grant      = o_imem_req & i_imem_gnt;
        rsp_ok     = i_imem_rvalid & (outst_q != '0);
        push       = rsp_ok & ~i_redirect & (drop_q == '0);
        inst_valid = count_q != '0;
        pop        = inst_valid & i_id_ready & ~i_redirect;
    end

    // Next-state computation for pointers, counters and fetch PC
    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        outst_d = outst_q + CW'(grant) - CW'(rsp_ok);
        ifw_d   = grant  ? ifw_q + PW'(1) : ifw_q;
        ifr_d   = rsp_ok ? ifr_q + PW'(1) : ifr_q;
        err_d   = err_q | (i_imem_rvalid & (outst_q == '0));

        if (i_redirect) begin
            // Flush: everything still owed by memory belongs to the old stream
            fpc_d   = i_redirect_addr & ALIGN_MASK;
            head_d  = tail_q;
            count_d = '0;
            drop_d  = outst_q - CW'(rsp_ok);
        end else begin
            if (grant) begin
                fpc_d = fpc_q + PCINC;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            ifr_q   <= '0;
            ifw_q   <= '0;
            count_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ifr_q   <= ifr_d;
            ifw_q   <= ifw_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    // Queue and in-flight PC storage writes
    always_ff @(posedge clk) begin
        if (grant) begin
            infl_pc[ifw_q] <= fpc_q;
        end
        if (push) begin
            inst_mem[tail_q] <= i_imem_rdata;
            pc_mem[tail_q]   <= infl_pc[ifr_q];
        end
    end

    // Head presentation; zero when empty
    always_comb begin
        head_pc      = inst_valid ? pc_mem[head_q] : '0;
        o_inst_valid = inst_valid;
        o_inst       = inst_valid ? inst_mem[head_q] : '0;
        o_inst_pc    = head_pc;
        o_next_pc    = head_pc + PCINC;
        o_imem_addr  = fpc_q;
        o_count      = count_q;
        o_err        = err_q;
    end

endmodule
